// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported unified memory shared by instruction fetch and load/store.
// Data has priority; fetch is guaranteed a grant after MAX_DSTREAK consecutive data grants.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              clock,
  input  logic              start,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              if_stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);

  state_e              state_q,     state_d;
  owner_e              owner_q,     owner_d;
  logic                we_q,        we_d;
  logic [3:0]          lat_q,       lat_d;
  logic [3:0]          streak_q,    streak_d;
  logic                if_ready_q,  if_ready_d;
  logic                d_ready_q,   d_ready_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic grant_data;

  // Fetch only overrides data once the streak has saturated with a fetch still waiting.
  assign grant_data = d_req && !(if_req && (streak_q == STREAK_MAX));

  always_comb begin
    // NOTE: every _d starts from a default so no path through the case leaves it unassigned (no latches).
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    lat_d       = lat_q;
    streak_d    = streak_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (d_req || if_req) begin
          state_d  = S_ACCESS;
          lat_d    = '0;
          mem_en_d = 1'b1;
          if (grant_data) begin
            owner_d     = OWN_DATA;
            we_d        = d_we;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            if (if_req && (streak_q != STREAK_MAX)) begin
              streak_d = streak_q + 4'd1;
            end
          end else begin
            owner_d     = OWN_FETCH;
            we_d        = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end

      S_ACCESS: begin
        if (lat_q == LAT_LAST) begin
          state_d  = S_DONE;
          lat_d    = '0;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            d_ready_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (start) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_FETCH;
      we_q        <= 1'b0;
      lat_q       <= '0;
      streak_q    <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      lat_q       <= lat_d;
      streak_q    <= streak_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_stall  = if_req & ~if_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: behavioural memory, scoreboard of expected completions,
// and cycle-exact checks of grant timing, priority, streak limit and mid-access reset.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          start;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ready;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_stall;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2), .MAX_DSTREAK(4)
  ) dut (
    .clock(clock), .start(start),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .if_stall(if_stall)
  );

  always #5 clock = ~clock;

  // Behavioural memory: unwritten words read back as a fixed scramble of their address.
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_5A5A;
  endfunction

  always @(negedge clock) begin
    if (mem_we) mem_model[mem_addr] = mem_wdata;
    mem_rdata = mem_en ? mem_word(mem_addr) : '0;
  end

  typedef struct {
    bit            is_data;
    bit            is_load;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb[$];
  int            rdy_cyc[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            n_ready  = 0;
  logic [DW-1:0] exp_d_rdata = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit is_data, input bit is_load, input logic [DW-1:0] rdata);
    exp_t e;
    e.is_data = is_data;
    e.is_load = is_load;
    e.rdata   = rdata;
    sb.push_back(e);
  endtask

  // Advance to the middle of the next cycle and retire any completion against the scoreboard.
  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (if_ready || d_ready) begin
      n_ready++;
      rdy_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_ready", {30'b0, if_ready, d_ready}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("ready_owner", {30'b0, if_ready, d_ready}, e.is_data ? 32'd1 : 32'd2);
        if (!e.is_data) begin
          check("if_rdata", if_rdata, e.rdata);
        end else begin
          if (e.is_load) exp_d_rdata = e.rdata;
          check("d_rdata", d_rdata, exp_d_rdata);
        end
      end
    end
  endtask

  task automatic wait_readies(input int n, input int budget);
    int target;
    target = n_ready + n;
    while ((n_ready < target) && (budget > 0)) begin
      tick();
      budget--;
    end
    if (n_ready < target) check("ready_timeout", n_ready, target);
  endtask

  task automatic check_spacing(input int first, input int count, input string tag);
    for (int i = 1; i < count; i++) begin
      check(tag, rdy_cyc[first + i] - rdy_cyc[first + i - 1], 32'd4);
    end
  endtask

  // Both requesters held: expect D,D,D,D,F twice, completions 4 cycles apart.
  task automatic contention(input string tag);
    int first;
    logic [DW-1:0] dv, fv;
    dv = mem_word(32'h2000_0040);
    fv = mem_word(32'h0040_0010);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push(1'b1, 1'b1, dv);
      push(1'b0, 1'b0, fv);
    end
    first   = rdy_cyc.size();
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h2000_0040;
    if_req  = 1'b1;
    if_addr = 32'h0040_0010;
    wait_readies(10, 60);
    d_req  = 1'b0;
    if_req = 1'b0;
    if (rdy_cyc.size() >= first + 10) check_spacing(first, 10, tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_en"},    mem_en,    32'd0);
    check({tag, "_mem_we"},    mem_we,    32'd0);
    check({tag, "_if_ready"},  if_ready,  32'd0);
    check({tag, "_d_ready"},   d_ready,   32'd0);
    check({tag, "_if_rdata"},  if_rdata,  32'd0);
    check({tag, "_d_rdata"},   d_rdata,   32'd0);
    check({tag, "_mem_addr"},  mem_addr,  32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    int c0;
    int first;
    mem_model[32'h0040_0000] = 32'h8C08_0004;

    // Reset held 2 cycles with both requests up.
    start   = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 32'h3000_0000;
    d_wdata = 32'h0;
    tick();
    check_reset_outputs("rst1");
    tick();
    check_reset_outputs("rst2");
    start = 1'b0;
    push(1'b1, 1'b1, mem_word(32'h3000_0000));
    wait_readies(1, 10);
    d_req  = 1'b0;
    if_req = 1'b0;

    // Single fetch, cycle-exact.
    tick();
    c0 = cyc;
    if_req  = 1'b1;
    if_addr = 32'h0040_0000;
    push(1'b0, 1'b0, 32'h8C08_0004);
    #1;
    check("f_c0_stall", if_stall, 32'd1);
    check("f_c0_en", mem_en, 32'd0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("f_acc_en", mem_en, 32'd1);
      check("f_acc_addr", mem_addr, 32'h0040_0000);
      check("f_acc_we", mem_we, 32'd0);
      check("f_acc_stall", if_stall, 32'd1);
    end
    tick();
    check("f_c3_ready", if_ready, 32'd1);
    check("f_c3_latency", cyc - c0, 32'd3);
    check("f_c3_stall", if_stall, 32'd0);
    check("f_c3_en", mem_en, 32'd0);
    if_req = 1'b0;

    // Store; the address is corrupted mid-access and must be ignored.
    tick();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 32'h1001_0008;
    d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 1'b0, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      check("st_en", mem_en, 32'd1);
      check("st_we", mem_we, 32'd1);
      check("st_addr", mem_addr, 32'h1001_0008);
      check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
      d_addr = 32'hFFFF_0000;
    end
    tick();
    check("st_ready", d_ready, 32'd1);
    check("st_we_off", mem_we, 32'd0);
    check("st_if_rdata_held", if_rdata, 32'h8C08_0004);
    d_req = 1'b0;
    d_we  = 1'b0;

    // Load back the stored word; request dropped mid-access.
    tick();
    c0 = cyc;
    d_req  = 1'b1;
    d_addr = 32'h1001_0008;
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    tick();
    d_req = 1'b0;
    wait_readies(1, 8);
    check("ld_latency", rdy_cyc[rdy_cyc.size() - 1] - c0, 32'd3);

    contention("cont1_gap");

    // Short data streak, then fetch alone must win immediately and clear the streak.
    tick();
    for (int k = 0; k < 3; k++) push(1'b1, 1'b1, mem_word(32'h2000_0040));
    push(1'b0, 1'b0, mem_word(32'h0040_0010));
    first   = rdy_cyc.size();
    d_req   = 1'b1;
    d_addr  = 32'h2000_0040;
    if_req  = 1'b1;
    if_addr = 32'h0040_0010;
    wait_readies(3, 20);
    d_req = 1'b0;
    wait_readies(1, 8);
    if_req = 1'b0;
    if (rdy_cyc.size() >= first + 4) check_spacing(first, 4, "alone_gap");

    contention("cont2_gap");

    // Mid-access reset during the second ACCESS cycle of a data grant.
    tick();
    push(1'b1, 1'b1, mem_word(32'h2000_0040));
    push(1'b1, 1'b1, mem_word(32'h2000_0040));
    d_req   = 1'b1;
    d_addr  = 32'h2000_0040;
    if_req  = 1'b1;
    if_addr = 32'h0040_0010;
    wait_readies(2, 20);
    tick();
    tick();
    check("mr_c1_en", mem_en, 32'd1);
    tick();
    check("mr_c2_en", mem_en, 32'd1);
    start  = 1'b1;
    d_req  = 1'b0;
    if_req = 1'b0;
    tick();
    check_reset_outputs("mr");
    start = 1'b0;
    tick();
    check("mr_idle_en", mem_en, 32'd0);
    check("mr_idle_ready", {30'b0, if_ready, d_ready}, 32'd0);
    check("mr_sb_drained", sb.size(), 32'd0);

    contention("cont3_gap");

    tick();
    tick();
    check("final_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
